// File: rtl/ltc2308_spi_responder_if.sv
// Pin-level bundle between an LTC2308 master (FIFO ADC front-end or bench) and the responder.
// The master drives the serial pins, the channel-value loader and the error clear.
interface ltc2308_spi_responder_if;
    logic        ADC_CONVST;
    logic        ADC_SCK;
    logic        ADC_SDI;
    logic        ADC_SDO;
    logic        smp_wr_en;
    logic [2:0]  smp_wr_ch;
    logic [11:0] smp_wr_data;
    logic        busy;
    logic [5:0]  last_cfg;
    logic [15:0] conv_count;
    logic        err_sck;
    logic        err_clr;

    modport master (
        output ADC_CONVST, ADC_SCK, ADC_SDI, smp_wr_en, smp_wr_ch, smp_wr_data, err_clr,
        input  ADC_SDO, busy, last_cfg, conv_count, err_sck
    );

    modport slave (
        input  ADC_CONVST, ADC_SCK, ADC_SDI, smp_wr_en, smp_wr_ch, smp_wr_data, err_clr,
        output ADC_SDO, busy, last_cfg, conv_count, err_sck
    );
endinterface

// File: rtl/ltc2308_spi_responder.sv
// Behavioural stand-in for an LTC2308 ADC: serves 8 loadable 12-bit channel values
// over CONVST/SCK/SDI/SDO, with the part's one-frame-delayed configuration pipeline.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, waiting for the first CONVST rise
// CONV  | conversion in progress, busy high, SCK edges flagged as errors
// SHIFT | result shifts out on SCK falls, config shifts in on SCK rises
module ltc2308_spi_responder #(
    parameter int         T_CONV_CYC = 64,
    parameter logic [5:0] CFG_RESET  = 6'h22
) (
    input  logic                          clk,
    input  logic                          reset_n,
    ltc2308_spi_responder_if.slave        bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    localparam int         CW       = (T_CONV_CYC > 2) ? $clog2(T_CONV_CYC) : 1;
    localparam logic [CW-1:0] CONV_LOAD = CW'(T_CONV_CYC - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_conv_tmr;
    logic [2:0]    r_convst_sync;
    logic [2:0]    r_sck_sync;
    logic [1:0]    r_sdi_sync;
    logic [11:0]   r_chreg [8];
    logic [5:0]    r_cfg_sr;
    logic [2:0]    r_cfg_cnt;
    logic [5:0]    r_eff_cfg;
    logic [5:0]    r_last_cfg;
    logic [11:0]   r_result;
    logic [11:0]   r_sdo_sr;
    logic [3:0]    r_sdo_cnt;
    logic [15:0]   r_conv_count;
    logic          r_err_sck;

    logic          w_convst_rise;
    logic          w_sck_rise;
    logic          w_sck_fall;
    logic          w_sdi;
    logic          w_err_evt;
    logic [5:0]    w_next_cfg;
    logic [2:0]    w_ch;
    logic [11:0]   w_raw;
    logic [11:0]   w_result;

    // Sync stage [1] is the settled sample, stage [2] its registered copy for edge detection.
    assign w_convst_rise = r_convst_sync[1] & ~r_convst_sync[2];
    assign w_sck_rise    = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall    = ~r_sck_sync[1] & r_sck_sync[2];
    assign w_sdi         = r_sdi_sync[1];
    assign w_err_evt     = (r_state == S_CONV) && (w_sck_rise || w_sck_fall);

    // Config word is {S/D, O/S, S1, S0, UNI, SLP}; only a complete frame replaces it.
    assign w_next_cfg = (r_cfg_cnt == 3'd6) ? r_cfg_sr : r_eff_cfg;
    assign w_ch       = {w_next_cfg[3], w_next_cfg[2], w_next_cfg[4]};
    assign w_raw      = r_chreg[w_ch];
    assign w_result   = !w_next_cfg[5] ? 12'h000 :
                        (w_next_cfg[1] ? w_raw : (w_raw ^ 12'h800));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_conv_tmr    <= '0;
            r_convst_sync <= '0;
            r_sck_sync    <= '0;
            r_sdi_sync    <= '0;
            for (int i = 0; i < 8; i++) r_chreg[i] <= '0;
            r_cfg_sr      <= '0;
            r_cfg_cnt     <= '0;
            r_eff_cfg     <= CFG_RESET;
            r_last_cfg    <= CFG_RESET;
            r_result      <= '0;
            r_sdo_sr      <= '0;
            r_sdo_cnt     <= '0;
            r_conv_count  <= '0;
            r_err_sck     <= 1'b0;
        end else begin
            r_convst_sync <= {r_convst_sync[1:0], bus.ADC_CONVST};
            r_sck_sync    <= {r_sck_sync[1:0], bus.ADC_SCK};
            r_sdi_sync    <= {r_sdi_sync[0], bus.ADC_SDI};

            // A same-cycle conversion start still latches the pre-write value.
            if (bus.smp_wr_en) r_chreg[bus.smp_wr_ch] <= bus.smp_wr_data;

            if (w_err_evt)        r_err_sck <= 1'b1;
            else if (bus.err_clr) r_err_sck <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_convst_rise) begin
                        r_state      <= S_CONV;
                        r_conv_tmr   <= CONV_LOAD;
                        r_eff_cfg    <= w_next_cfg;
                        r_last_cfg   <= w_next_cfg;
                        r_result     <= w_result;
                        r_conv_count <= r_conv_count + 16'd1;
                        r_cfg_cnt    <= '0;
                    end
                end
                S_CONV: begin
                    if (r_conv_tmr == '0) begin
                        r_state   <= S_SHIFT;
                        r_sdo_sr  <= r_result;
                        r_sdo_cnt <= '0;
                    end else begin
                        r_conv_tmr <= r_conv_tmr - 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_convst_rise) begin
                        r_state      <= S_CONV;
                        r_conv_tmr   <= CONV_LOAD;
                        r_eff_cfg    <= w_next_cfg;
                        r_last_cfg   <= w_next_cfg;
                        r_result     <= w_result;
                        r_conv_count <= r_conv_count + 16'd1;
                        r_cfg_cnt    <= '0;
                    end else if (w_sck_fall) begin
                        if (r_sdo_cnt < 4'd12) begin
                            r_sdo_sr  <= {r_sdo_sr[10:0], 1'b0};
                            r_sdo_cnt <= r_sdo_cnt + 4'd1;
                        end
                    end else if (w_sck_rise) begin
                        if (r_cfg_cnt < 3'd6) begin
                            r_cfg_sr  <= {r_cfg_sr[4:0], w_sdi};
                            r_cfg_cnt <= r_cfg_cnt + 3'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ADC_SDO    = r_sdo_sr[11];
    assign bus.busy       = (r_state == S_CONV);
    assign bus.last_cfg   = r_last_cfg;
    assign bus.conv_count = r_conv_count;
    assign bus.err_sck    = r_err_sck;
endmodule

// File: tb/tb_ltc2308_spi_responder.sv
// Directed bench for ltc2308_spi_responder: a table of frames with hand-computed
// results plus sequences for SCK-during-conversion and reset mid-frame.
module tb_ltc2308_spi_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ltc2308_spi_responder_if bus ();

    ltc2308_spi_responder #(.T_CONV_CYC(64), .CFG_RESET(6'h22)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [2:0]  wr_ch;
        logic [11:0] wr_data;
        logic [5:0]  sdi_cfg;
        int          n_sck;
        logic [11:0] exp_word;
        logic [5:0]  exp_cfg;
    } vec_t;

    vec_t vecs[9];

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_ch(input logic [2:0] ch, input logic [11:0] data);
        bus.smp_wr_en   = 1'b1;
        bus.smp_wr_ch   = ch;
        bus.smp_wr_data = data;
        tick(1);
        bus.smp_wr_en   = 1'b0;
        tick(1);
    endtask

    // One frame: CONVST pulse, wait out the conversion, then n SCK periods
    // (4 clk half-period). Returns the n SDO bits sampled while SCK is high.
    task automatic do_frame(input logic [5:0] sdi, input int n, input bit glitch,
                            output logic [11:0] word);
        word = '0;
        bus.ADC_CONVST = 1'b1;
        tick(4);
        bus.ADC_CONVST = 1'b0;
        if (glitch) begin
            tick(16);
            bus.ADC_SCK = 1'b1;
            tick(4);
            bus.ADC_SCK = 1'b0;
            tick(4);
            check("err_set_in_conv", {15'd0, bus.err_sck}, 16'd1);
            check("busy_during_conv", {15'd0, bus.busy}, 16'd1);
            tick(46);
        end else begin
            tick(70);
        end
        check("busy_after_conv", {15'd0, bus.busy}, 16'd0);
        for (int i = 0; i < n; i++) begin
            bus.ADC_SDI = (i < 6) ? sdi[5 - i] : 1'b0;
            tick(4);
            bus.ADC_SCK = 1'b1;
            tick(4);
            word = {word[10:0], bus.ADC_SDO};
            bus.ADC_SCK = 1'b0;
        end
        bus.ADC_SDI = 1'b0;
        tick(6);
    endtask

    initial begin
        logic [11:0] word;
        logic [11:0] exp_bits;

        vecs[0] = '{3'd0, 12'hABC, 6'b110010, 12, 12'hABC, 6'h22};
        vecs[1] = '{3'd1, 12'h123, 6'b110000, 12, 12'h123, 6'h32};
        vecs[2] = '{3'd2, 12'h456, 6'b000010, 12, 12'h923, 6'h30};
        vecs[3] = '{3'd0, 12'h7FF, 6'b110110, 12, 12'h000, 6'h02};
        vecs[4] = '{3'd3, 12'hFFF, 6'b000000,  3, 12'hFFF, 6'h36};
        vecs[5] = '{3'd5, 12'h001, 6'b100000, 12, 12'hFFF, 6'h36};
        vecs[6] = '{3'd0, 12'h234, 6'b100010, 12, 12'hA34, 6'h20};
        vecs[7] = '{3'd7, 12'hABC, 6'b111111, 12, 12'h234, 6'h22};
        vecs[8] = '{3'd1, 12'h000, 6'b110110, 12, 12'hABC, 6'h3F};

        bus.ADC_CONVST  = 1'b0;
        bus.ADC_SCK     = 1'b0;
        bus.ADC_SDI     = 1'b0;
        bus.smp_wr_en   = 1'b0;
        bus.smp_wr_ch   = '0;
        bus.smp_wr_data = '0;
        bus.err_clr     = 1'b0;
        tick(4);
        reset_n = 1'b1;
        tick(2);

        check("rst_sdo",        {15'd0, bus.ADC_SDO}, 16'd0);
        check("rst_busy",       {15'd0, bus.busy},    16'd0);
        check("rst_last_cfg",   {10'd0, bus.last_cfg}, 16'h0022);
        check("rst_conv_count", bus.conv_count,       16'd0);
        check("rst_err_sck",    {15'd0, bus.err_sck}, 16'd0);

        for (int v = 0; v < 9; v++) begin
            write_ch(vecs[v].wr_ch, vecs[v].wr_data);
            do_frame(vecs[v].sdi_cfg, vecs[v].n_sck, 1'b0, word);
            exp_bits = vecs[v].exp_word >> (12 - vecs[v].n_sck);
            check($sformatf("vec%0d_word", v), {4'd0, word}, {4'd0, exp_bits});
            check($sformatf("vec%0d_last_cfg", v), {10'd0, bus.last_cfg}, {10'd0, vecs[v].exp_cfg});
        end
        check("conv_count_9", bus.conv_count, 16'd9);
        check("no_err_yet", {15'd0, bus.err_sck}, 16'd0);

        // SCK toggled mid-conversion: sticky error, data unaffected, clear works.
        write_ch(3'd3, 12'h5A5);
        do_frame(6'b110110, 12, 1'b1, word);
        check("err_frame_word", {4'd0, word}, 16'h05A5);
        check("err_frame_cfg",  {10'd0, bus.last_cfg}, 16'h0036);
        check("err_sticky",     {15'd0, bus.err_sck}, 16'd1);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        tick(1);
        check("err_cleared",    {15'd0, bus.err_sck}, 16'd0);

        // Partial frame of 4 bits, then reset while SDO holds result bit 7.
        do_frame(6'b000000, 4, 1'b0, word);
        check("partial_word",   {4'd0, word}, 16'h0005);
        check("sdo_before_rst", {15'd0, bus.ADC_SDO}, 16'd1);
        check("count_before_rst", bus.conv_count, 16'd11);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check("midrst_sdo",      {15'd0, bus.ADC_SDO}, 16'd0);
        check("midrst_busy",     {15'd0, bus.busy},    16'd0);
        check("midrst_count",    bus.conv_count,       16'd0);
        check("midrst_last_cfg", {10'd0, bus.last_cfg}, 16'h0022);
        do_frame(6'b100010, 12, 1'b0, word);
        check("post_rst_word",   {4'd0, word}, 16'h0000);
        check("post_rst_cfg",    {10'd0, bus.last_cfg}, 16'h0022);
        check("post_rst_count",  bus.conv_count, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
